// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter snooping the CPU store bus.
// Stores to TX_ADDR are queued in a small FIFO and serialized LSB first on tx.
// Ports:
//   clk, reset         - clock, synchronous active-high reset
//   mem_write          - CPU store strobe
//   data_addr          - CPU store address (exact 32-bit match against TX_ADDR)
//   write_data         - CPU store data, byte [7:0] is transmitted
//   tx                 - serial line, idle high, registered
//   busy               - FSM active or FIFO non-empty
//   fifo_full          - FIFO holds FIFO_DEPTH bytes
//   overflow           - sticky, a store was dropped because the FIFO was full
//   tx_count           - completed frames, wrapping
module mmio_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter logic [31:0] TX_ADDR      = 32'hFFFF_FFF0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_write,
  input  logic [31:0] data_addr,
  input  logic [31:0] write_data,
  output logic        tx,
  output logic        busy,
  output logic        fifo_full,
  output logic        overflow,
  output logic [15:0] tx_count
);

  localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W    = PTR_W + 1;
  localparam int unsigned BAUD_W   = $clog2(CLKS_PER_BIT);
  localparam int unsigned BAUD_MAX = CLKS_PER_BIT - 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t              r_state;
  logic [BAUD_W-1:0]   r_baud;
  logic [2:0]          r_bit;
  logic [7:0]          r_shift;
  logic                r_tx;
  logic [7:0]          r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]    r_count;
  logic                r_busy;
  logic                r_fifo_full;
  logic                r_overflow;
  logic [15:0]         r_tx_count;

  state_t              w_state_nxt;
  logic [BAUD_W-1:0]   w_baud_nxt;
  logic [2:0]          w_bit_nxt;
  logic [7:0]          w_shift_nxt;
  logic                w_tx_nxt;
  logic                w_pop;
  logic                w_frame_done;
  logic                w_push;
  logic                w_push_ok;
  logic                w_empty;
  logic                w_full;
  logic                w_baud_end;
  logic [CNT_W-1:0]    w_count_nxt;
  logic                w_unused_data;

  assign w_push        = mem_write && (data_addr == TX_ADDR);
  assign w_empty       = (r_count == '0);
  assign w_full        = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_baud_end    = (r_baud == BAUD_W'(BAUD_MAX));
  // A full FIFO still accepts a store when the head leaves on the same edge.
  assign w_push_ok     = w_push && (!w_full || w_pop);
  assign w_unused_data = ^write_data[31:8];

  // Next-state, serializer and pop decode.
  always_comb begin
    w_state_nxt  = r_state;
    w_baud_nxt   = r_baud + BAUD_W'(1);
    w_bit_nxt    = r_bit;
    w_shift_nxt  = r_shift;
    w_tx_nxt     = r_tx;
    w_pop        = 1'b0;
    w_frame_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_tx_nxt   = 1'b1;
        w_baud_nxt = '0;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = r_mem[r_rd_ptr];
          w_state_nxt = S_START;
          w_tx_nxt    = 1'b0;
        end
      end
      S_START: begin
        if (w_baud_end) begin
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
          w_state_nxt = S_DATA;
          w_tx_nxt    = r_shift[0];
        end
      end
      S_DATA: begin
        if (w_baud_end) begin
          w_baud_nxt = '0;
          if (r_bit == 3'd7) begin
            w_state_nxt = S_STOP;
            w_tx_nxt    = 1'b1;
          end else begin
            // Present the next bit from the register so tx stays a flop output.
            w_shift_nxt = {1'b0, r_shift[7:1]};
            w_tx_nxt    = r_shift[1];
            w_bit_nxt   = r_bit + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (w_baud_end) begin
          w_baud_nxt   = '0;
          w_frame_done = 1'b1;
          if (!w_empty) begin
            // Chain straight into the next start bit, no idle gap.
            w_pop       = 1'b1;
            w_shift_nxt = r_mem[r_rd_ptr];
            w_state_nxt = S_START;
            w_tx_nxt    = 1'b0;
          end else begin
            w_state_nxt = S_IDLE;
            w_tx_nxt    = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_tx_nxt    = 1'b1;
        w_baud_nxt  = '0;
      end
    endcase
  end

  // FIFO occupancy after this edge.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push_ok, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // FIFO storage; contents need no reset, the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= write_data[7:0];
    end
  end

  // State, pointers and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_baud      <= '0;
      r_bit       <= '0;
      r_shift     <= '0;
      r_tx        <= 1'b1;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_busy      <= 1'b0;
      r_fifo_full <= 1'b0;
      r_overflow  <= 1'b0;
      r_tx_count  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_baud      <= w_baud_nxt;
      r_bit       <= w_bit_nxt;
      r_shift     <= w_shift_nxt;
      r_tx        <= w_tx_nxt;
      r_count     <= w_count_nxt;
      r_busy      <= (w_state_nxt != S_IDLE) || (w_count_nxt != '0);
      r_fifo_full <= (w_count_nxt == CNT_W'(FIFO_DEPTH));
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_push && !w_push_ok) begin
        r_overflow <= 1'b1;
      end
      if (w_frame_done) begin
        r_tx_count <= r_tx_count + 16'd1;
      end
    end
  end

  assign tx        = r_tx;
  assign busy      = r_busy;
  assign fifo_full = r_fifo_full;
  assign overflow  = r_overflow;
  assign tx_count  = r_tx_count;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: directed table-driven bench for mmio_uart_tx (4 clocks/bit, 4-deep FIFO).
module tb_mmio_uart_tx;

  localparam int unsigned CPB = 4;
  localparam logic [31:0] TXA = 32'hFFFF_FFF0;

  logic        clk;
  logic        reset;
  logic        mem_write;
  logic [31:0] data_addr;
  logic [31:0] write_data;
  logic        tx;
  logic        busy;
  logic        fifo_full;
  logic        overflow;
  logic [15:0] tx_count;

  int n_checks;
  int n_fail;
  logic [15:0] exp_count;

  mmio_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (4),
    .TX_ADDR     (TXA)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_write (mem_write),
    .data_addr (data_addr),
    .write_data(write_data),
    .tx        (tx),
    .busy      (busy),
    .fifo_full (fifo_full),
    .overflow  (overflow),
    .tx_count  (tx_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        accept;
    logic [7:0]  exp_byte;
  } vec_t;

  vec_t vecs [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected tx level j cycles into a frame carrying byte b (j = 0 is the start edge).
  function automatic logic frame_bit(input int j, input logic [7:0] b);
    int bi;
    bi = j / CPB;
    if (bi == 0) return 1'b0;
    if (bi >= 9) return 1'b1;
    return b[bi-1];
  endfunction

  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    mem_write  = 1'b1;
    data_addr  = addr;
    write_data = data;
  endtask

  task automatic idle_bus();
    mem_write  = 1'b0;
    data_addr  = 32'h0;
    write_data = 32'h0;
  endtask

  // One store then the full frame window, checked cycle by cycle.
  task automatic send_check(input vec_t v);
    logic exp_tx;
    store(v.addr, v.data);
    tick();
    idle_bus();
    chk("post-store tx", 32'(tx), 32'h1);
    chk("post-store busy", 32'(busy), 32'(v.accept));
    for (int j = 1; j <= 10 * CPB; j++) begin
      tick();
      exp_tx = v.accept ? frame_bit(j - 1, v.exp_byte) : 1'b1;
      chk("frame tx", 32'(tx), 32'(exp_tx));
    end
    tick();
    if (v.accept) exp_count = exp_count + 16'd1;
    chk("tx_count after frame", 32'(tx_count), 32'(exp_count));
    chk("busy after frame", 32'(busy), 32'h0);
    chk("tx idle after frame", 32'(tx), 32'h1);
  endtask

  initial begin
    logic [7:0] ovf_bytes [5];
    logic [7:0] b0;
    n_checks  = 0;
    n_fail    = 0;
    exp_count = 16'd0;

    vecs[0] = '{TXA,           32'h0000_0055, 1'b1, 8'h55};
    vecs[1] = '{32'hFFFF_FFF4, 32'hDEAD_BE41, 1'b0, 8'h00};
    vecs[2] = '{TXA,           32'hDEAD_BE41, 1'b1, 8'h41};
    vecs[3] = '{32'h7FFF_FFF0, 32'h0000_00AA, 1'b0, 8'h00};
    vecs[4] = '{TXA,           32'h1234_56A3, 1'b1, 8'hA3};
    vecs[5] = '{TXA,           32'h0000_00FF, 1'b1, 8'hFF};
    vecs[6] = '{TXA,           32'hFFFF_FF00, 1'b1, 8'h00};

    // Reset state.
    idle_bus();
    reset = 1'b1;
    tick();
    tick();
    chk("reset tx", 32'(tx), 32'h1);
    chk("reset busy", 32'(busy), 32'h0);
    chk("reset fifo_full", 32'(fifo_full), 32'h0);
    chk("reset overflow", 32'(overflow), 32'h0);
    chk("reset tx_count", 32'(tx_count), 32'h0);
    reset = 1'b0;
    tick();

    // Table: single frames and address/byte filtering.
    for (int i = 0; i < 7; i++) begin
      send_check(vecs[i]);
    end
    chk("no overflow yet", 32'(overflow), 32'h0);

    // Overflow: bytes A..F on six consecutive edges; F is dropped.
    for (int i = 0; i < 5; i++) ovf_bytes[i] = 8'h41 + 8'(i);
    store(TXA, 32'h0000_0041);
    tick();
    chk("ovf fifo_full after 1st", 32'(fifo_full), 32'h0);
    store(TXA, 32'h0000_0042);
    tick();
    // Now just after the edge where A popped and its start bit began.
    for (int j = 0; j < 5 * 10 * CPB; j++) begin
      chk("b2b tx", 32'(tx), 32'(frame_bit(j % (10 * CPB), ovf_bytes[j / (10 * CPB)])));
      if (j == 3) chk("fifo_full after 5th store", 32'(fifo_full), 32'h1);
      if (j == 4) begin
        chk("overflow after 6th store", 32'(overflow), 32'h1);
        chk("fifo_full stays after drop", 32'(fifo_full), 32'h1);
      end
      if (j < 4) store(TXA, 32'(8'h43 + 8'(j)));
      else idle_bus();
      tick();
    end
    exp_count = exp_count + 16'd5;
    chk("tx_count after burst", 32'(tx_count), 32'(exp_count));
    chk("busy after burst", 32'(busy), 32'h0);
    chk("overflow sticky", 32'(overflow), 32'h1);

    // Reset mid-frame during data bit 3 with two bytes still queued.
    b0 = 8'h5A;
    store(TXA, 32'(b0));
    tick();
    store(TXA, 32'h0000_0033);
    tick();
    store(TXA, 32'h0000_00C3);
    tick();
    idle_bus();
    for (int j = 0; j < 15; j++) tick();
    chk("mid-frame data bit 3", 32'(tx), 32'(b0[3]));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_count = 16'd0;
    chk("mid-reset tx", 32'(tx), 32'h1);
    chk("mid-reset busy", 32'(busy), 32'h0);
    chk("mid-reset tx_count", 32'(tx_count), 32'(exp_count));
    chk("mid-reset overflow", 32'(overflow), 32'h0);
    chk("mid-reset fifo_full", 32'(fifo_full), 32'h0);
    for (int j = 0; j < 12 * CPB; j++) begin
      tick();
      chk("post-reset line idle", 32'(tx), 32'h1);
    end
    chk("post-reset busy", 32'(busy), 32'h0);
    chk("post-reset tx_count", 32'(tx_count), 32'h0);

    // Counter wrap from 16'hFFFF.
    dut.r_tx_count = 16'hFFFF;
    exp_count = 16'hFFFF;
    tick();
    chk("deposit tx_count", 32'(tx_count), 32'h0000_FFFF);
    send_check(vecs[0]);
    chk("wrapped tx_count", 32'(tx_count), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
